pixel_state_ctrl: RTL and testbench
===================================

Name: pixel_state_ctrl

Overview:
- Frame sequencer upstream of the pixel row/array. Drives the shared ERASE, EXPOSE, RAMP and COUNTER lines and a one-hot per-row READ.
- Runs one frame per start: erase, expose, convert (ramp plus 8-bit counter sweep), then row-by-row readout.
- Each row's DATA_OUT is handed to the downstream consumer with a valid/ready handshake.

Parameters:
- PIXEL_ARRAY_HEIGHT, 2, number of rows; READ and row_sel are sized from it (1..16).
- C_ERASE_CYCLES, 5, clocks ERASE is held high (1..65535).
- C_EXPOSE_CYCLES, 255, clocks EXPOSE is held high (1..65535).
- C_CONVERT_CYCLES, 255, clocks RAMP is high and COUNTER sweeps (1..256).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled only in IDLE.
- ERASE  output  1  pixel erase.
- EXPOSE  output  1  pixel expose.
- RAMP  output  1  comparator ramp enable during conversion.
- COUNTER  output  8  conversion code to pixel latches.
- READ  output  PIXEL_ARRAY_HEIGHT  one-hot row read enable.
- row_sel  output  max(1,$clog2(PIXEL_ARRAY_HEIGHT))  index of the row currently read.
- row_valid  output  1  selected row's DATA_OUT is stable.
- row_ready  input  1  consumer accepts the row.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset: asynchronous. State goes to IDLE and every output is 0, including COUNTER=0, READ=0, row_sel=0 and the internal 16-bit phase timer. Asserting reset mid-frame aborts the frame; no frame_done is produced.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ_SETTLE, READ_XFER. All outputs are registered.
- IDLE: all outputs 0. If start=1 at a clock edge, the next state is ERASE and the timer is cleared.
- ERASE: ERASE=1 for exactly C_ERASE_CYCLES clocks, then EXPOSE.
- EXPOSE: EXPOSE=1 for exactly C_EXPOSE_CYCLES clocks, then CONVERT.
- CONVERT: RAMP=1 for exactly C_CONVERT_CYCLES clocks.
  - COUNTER=0 in the first CONVERT cycle and increments by 1 each clock, reaching C_CONVERT_CYCLES-1. With the value 256 it ends at 255 and never wraps.
  - On exit COUNTER returns to 0, RAMP goes to 0 and row_sel=0.
- READ_SETTLE: READ[row_sel]=1 and row_valid=0 for one clock (latch/bus settling), then READ_XFER.
- READ_XFER: READ[row_sel] stays 1 and row_valid=1.
  - The state holds indefinitely while row_ready=0; no output changes.
  - A transfer occurs on a clock with row_valid=1 and row_ready=1. If row_sel < PIXEL_ARRAY_HEIGHT-1, increment row_sel and go to READ_SETTLE.
  - If the transfer is on the last row: go to IDLE, pulse frame_done=1 in the following cycle, and clear READ and row_sel.
- Invariants:
  - ERASE, EXPOSE, RAMP and READ are mutually exclusive.
  - READ is never two-hot.
  - row_valid implies exactly one READ bit is set.
- start while busy is ignored and not queued. start held high in IDLE launches a new frame on the edge after frame_done's cycle; IDLE always lasts at least 1 cycle.
- row_ready while row_valid=0 has no effect.
- Frame length without stalls: 1 + C_ERASE_CYCLES + C_EXPOSE_CYCLES + C_CONVERT_CYCLES + 2*PIXEL_ARRAY_HEIGHT clocks from the start edge to frame_done.

Optional Feature:
- Macro: PIXEL_STATE_CTRL_CONTINUOUS_EN.
- Defined: after the last-row transfer, go directly to ERASE instead of IDLE; frame_done still pulses for 1 cycle and busy stays 1. Frames run back to back regardless of start until reset.
- Undefined: single-shot behaviour exactly as above.

Test Plan:
- Reset mid-EXPOSE (defaults, reset at cycle 50) -> all outputs 0 asynchronously before the next edge; state IDLE; no frame_done.
- Defaults, start pulsed 1 cycle, row_ready=1 -> ERASE high 5 clocks, EXPOSE high 255, RAMP high 255 with COUNTER 0..254 then 0. READ=01 then 10, each row_valid for 1 cycle. frame_done exactly 1+5+255+255+4 = 520 clocks after the start edge.
- C_CONVERT_CYCLES=256 -> COUNTER reaches 255 in the last RAMP cycle and is 0 the next cycle, with no wrap glitch.
- row_ready=0 for 10 cycles on row 0 -> READ=01, row_valid=1 and row_sel=0 held stable for all 10 cycles. Row 1 begins only after the handshake; frame_done is delayed by 10.
- start asserted during CONVERT and left high -> no effect on the current frame; a new ERASE starts 2 clocks after the last-row transfer edge.
- PIXEL_STATE_CTRL_CONTINUOUS_EN defined, start pulsed once -> ERASE re-enters the cycle after the last transfer. frame_done pulses once per frame across 3 frames; busy never drops.

Source files
------------

// File: rtl/pixel_state_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion, then handshaked row readout.
// Optional build macro PIXEL_STATE_CTRL_CONTINUOUS_EN: frames repeat back to back without returning to IDLE.
//
// state         | meaning
// S_IDLE        | waiting for start; all lines low
// S_ERASE       | ERASE held high for C_ERASE_CYCLES clocks
// S_EXPOSE      | EXPOSE held high for C_EXPOSE_CYCLES clocks
// S_CONVERT     | RAMP high, COUNTER sweeps up from 0
// S_READ_SETTLE | selected row's READ high, data bus settling
// S_READ_XFER   | selected row's data offered with row_valid, waiting for row_ready
module pixel_state_ctrl #(
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int C_ERASE_CYCLES     = 5,
  parameter int C_EXPOSE_CYCLES    = 255,
  parameter int C_CONVERT_CYCLES   = 255,
  localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          ERASE,
  output logic                          EXPOSE,
  output logic                          RAMP,
  output logic [7:0]                    COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0] READ,
  output logic [ROW_W-1:0]              row_sel,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic                          busy,
  output logic                          frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ_SETTLE, S_READ_XFER
  } state_t;

  localparam logic [15:0]      ERASE_LOAD   = 16'(C_ERASE_CYCLES - 1);
  localparam logic [15:0]      EXPOSE_LOAD  = 16'(C_EXPOSE_CYCLES - 1);
  localparam logic [15:0]      CONVERT_LOAD = 16'(C_CONVERT_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

  state_t                        state_q, state_d;
  logic [15:0]                   timer_q, timer_d;
  logic [7:0]                    cnt_d;
  logic [ROW_W-1:0]              row_d;
  logic                          pend_q, pend_d;
  logic [PIXEL_ARRAY_HEIGHT-1:0] read_d;

  // Phase timers count down from (cycles-1); the phase ends on the terminal count of zero.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    row_d   = row_sel;
    cnt_d   = 8'd0;
    pend_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // pend_q keeps IDLE alive for the frame_done cycle before start is honoured
        if (start && !pend_q) begin
          state_d = S_ERASE;
          timer_d = ERASE_LOAD;
        end
      end
      S_ERASE: begin
        if (timer_q == 16'd0) begin
          state_d = S_EXPOSE;
          timer_d = EXPOSE_LOAD;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_EXPOSE: begin
        if (timer_q == 16'd0) begin
          state_d = S_CONVERT;
          timer_d = CONVERT_LOAD;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_CONVERT: begin
        if (timer_q == 16'd0) begin
          state_d = S_READ_SETTLE;
          row_d   = '0;
        end else begin
          timer_d = timer_q - 16'd1;
          cnt_d   = COUNTER + 8'd1;
        end
      end
      S_READ_SETTLE: state_d = S_READ_XFER;
      S_READ_XFER: begin
        if (row_ready) begin
          if (row_sel == LAST_ROW) begin
            pend_d = 1'b1;
            row_d  = '0;
`ifdef PIXEL_STATE_CTRL_CONTINUOUS_EN
            state_d = S_ERASE;
            timer_d = ERASE_LOAD;
`else
            state_d = S_IDLE;
`endif
          end else begin
            row_d   = row_sel + ROW_W'(1);
            state_d = S_READ_SETTLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    read_d = '0;
    if (state_d == S_READ_SETTLE || state_d == S_READ_XFER) read_d[row_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pend_q     <= 1'b0;
      row_sel    <= '0;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      RAMP       <= 1'b0;
      COUNTER    <= 8'd0;
      READ       <= '0;
      row_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      row_sel    <= row_d;
      ERASE      <= (state_d == S_ERASE);
      EXPOSE     <= (state_d == S_EXPOSE);
      RAMP       <= (state_d == S_CONVERT);
      COUNTER    <= cnt_d;
      READ       <= read_d;
      row_valid  <= (state_d == S_READ_XFER);
      busy       <= (state_d != S_IDLE);
      frame_done <= pend_q;
    end
  end

endmodule

// File: tb/tb_pixel_state_ctrl.sv
// Randomized bench for pixel_state_ctrl: two instances (default and a small 3-row / 256-step build)
// checked every cycle against a frame-timeline reference model.
module tb_pixel_state_ctrl;

  logic clk = 1'b0;
  logic reset, start, row_ready;

  logic       e0, x0, r0, v0, b0, f0;
  logic [7:0] c0;
  logic [1:0] rd0;
  logic [0:0] rs0;
  logic       e1, x1, r1, v1, b1, f1;
  logic [7:0] c1;
  logic [2:0] rd1;
  logic [1:0] rs1;

  pixel_state_ctrl dut0 (
    .clk(clk), .reset(reset), .start(start), .ERASE(e0), .EXPOSE(x0), .RAMP(r0),
    .COUNTER(c0), .READ(rd0), .row_sel(rs0), .row_valid(v0), .row_ready(row_ready),
    .busy(b0), .frame_done(f0));

  pixel_state_ctrl #(.PIXEL_ARRAY_HEIGHT(3), .C_ERASE_CYCLES(2), .C_EXPOSE_CYCLES(3),
                     .C_CONVERT_CYCLES(256)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ERASE(e1), .EXPOSE(x1), .RAMP(r1),
    .COUNTER(c1), .READ(rd1), .row_sel(rs1), .row_valid(v1), .row_ready(row_ready),
    .busy(b1), .frame_done(f1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a timeline t (ERASE, EXPOSE, RAMP phases by arithmetic on t)
  // followed by a readout walk over rows, each row a settle beat then a wait for ready.
  int m_e[2] = '{5, 2};
  int m_x[2] = '{255, 3};
  int m_c[2] = '{255, 256};
  int m_h[2] = '{2, 3};
  bit m_act[2], m_rd[2], m_settle[2], m_pend[2], m_fd[2];
  int m_t[2], m_row[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_rd[k] = 0; m_settle[k] = 0; m_pend[k] = 0; m_fd[k] = 0;
      m_t[k] = 0; m_row[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit st, input bit rdy);
    bit p;
    p = m_pend[k];
    m_fd[k] = p;
    m_pend[k] = 0;
    if (!m_act[k]) begin
      if (st && !p) begin
        m_act[k] = 1; m_t[k] = 0; m_rd[k] = 0;
      end
    end else if (!m_rd[k]) begin
      m_t[k]++;
      if (m_t[k] == m_e[k] + m_x[k] + m_c[k]) begin
        m_rd[k] = 1; m_row[k] = 0; m_settle[k] = 1;
      end
    end else if (m_settle[k]) begin
      m_settle[k] = 0;
    end else if (rdy) begin
      if (m_row[k] == m_h[k] - 1) begin
        m_pend[k] = 1;
`ifdef PIXEL_STATE_CTRL_CONTINUOUS_EN
        m_t[k] = 0; m_rd[k] = 0;
`else
        m_act[k] = 0; m_rd[k] = 0;
`endif
      end else begin
        m_row[k]++; m_settle[k] = 1;
      end
    end
  endtask

  function automatic logic [63:0] exp_vec(input int k);
    logic er, ex, ra, rv, rdg;
    logic [7:0]  cnt;
    logic [15:0] rd;
    logic [3:0]  rs;
    rdg = m_act[k] && m_rd[k];
    er  = m_act[k] && !m_rd[k] && (m_t[k] < m_e[k]);
    ex  = m_act[k] && !m_rd[k] && (m_t[k] >= m_e[k]) && (m_t[k] < m_e[k] + m_x[k]);
    ra  = m_act[k] && !m_rd[k] && (m_t[k] >= m_e[k] + m_x[k]);
    cnt = ra ? 8'(m_t[k] - m_e[k] - m_x[k]) : 8'd0;
    rd  = rdg ? (16'd1 << m_row[k]) : 16'd0;
    rs  = rdg ? 4'(m_row[k]) : 4'd0;
    rv  = rdg && !m_settle[k];
    return {30'd0, er, ex, ra, cnt, rd, rs, rv, m_act[k], m_fd[k]};
  endfunction

  function automatic logic [63:0] act0();
    return {30'd0, e0, x0, r0, c0, 14'd0, rd0, 3'd0, rs0, v0, b0, f0};
  endfunction

  function automatic logic [63:0] act1();
    return {30'd0, e1, x1, r1, c1, 13'd0, rd1, 2'd0, rs1, v1, b1, f1};
  endfunction

  // One clock: model follows the inputs seen at the edge, outputs compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step(0, start, row_ready);
    model_step(1, start, row_ready);
    @(negedge clk);
    chk("dut0_outputs", act0(), exp_vec(0));
    chk("dut1_outputs", act1(), exp_vec(1));
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, len0, len1, dones;
    bit hold, stall;
    start = 1'b0;
    row_ready = 1'b0;
    sync_reset();
    chk("reset_dut0", act0(), 64'd0);
    chk("reset_dut1", act1(), 64'd0);

    // single frame, no stalls: start edge to frame_done
    start = 1'b1;
    row_ready = 1'b1;
    cycle();
    start = 1'b0;
    n = 1; len0 = -1; len1 = -1;
    while ((len0 < 0 || len1 < 0) && n < 3000) begin
      cycle();
      n++;
      if (f0 && len0 < 0) len0 = n - 1;
      if (f1 && len1 < 0) len1 = n - 1;
    end
    chk("frame_len_dut0", 64'(len0), 64'(1 + 5 + 255 + 255 + 2 * 2));
    chk("frame_len_dut1", 64'(len1), 64'(1 + 2 + 3 + 256 + 2 * 3));

    // random start / ready, with blocks of held start and long ready stalls
    hold = 0; stall = 0;
    for (int i = 0; i < 8000; i++) begin
      if (i % 400 == 0) begin
        hold  = ($urandom_range(0, 1) == 1);
        stall = ($urandom_range(0, 2) == 0);
      end
      start     = hold ? 1'b1 : ($urandom_range(0, 15) == 0);
      row_ready = stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
      cycle();
    end

    // abort mid-EXPOSE with an asynchronous reset
    start = 1'b0;
    sync_reset();
    start = 1'b1;
    row_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (49) cycle();
    chk("pre_reset_expose", 64'(x0), 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_dut0", act0(), 64'd0);
    chk("async_reset_dut1", act1(), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 700; i++) begin
      cycle();
      if (f0 || f1) dones++;
    end
    chk("no_done_after_abort", 64'(dones), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
